// File: rtl/store_unit.sv
`default_nettype none
// store_unit: byte/half/full store engine; sub-word stores do read-modify-write on one memory word.
// Revision 1.0 -- initial release
module store_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        ss_ctrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NBYTES  = DATA_W / 8;
  localparam int NHALVES = DATA_W / 16;
  localparam int OFF_W   = $clog2(NBYTES);
  localparam int HOFF_W  = OFF_W - 1;

  localparam logic [1:0] SS_FULL = 2'b00;
  localparam logic [1:0] SS_HALF = 2'b01;
  localparam logic [1:0] SS_BYTE = 2'b10;
  localparam logic [1:0] SS_RSVD = 2'b11;

  localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        ss_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merged;
  logic [2:0]        wait_cnt;
  logic              accept;
  logic              misaligned;
  logic              wait_last;

  assign accept     = (state == S_IDLE) && start;
  assign misaligned = ((ss_ctrl == SS_HALF) && addr[0]) ||
                      ((ss_ctrl == SS_FULL) && (addr[OFF_W-1:0] != '0));
  assign wait_last  = (state == S_WAIT) && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if ((ss_ctrl == SS_RSVD) || misaligned) begin
            state_nxt = S_ERR;
          end else if (ss_ctrl == SS_FULL) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        mem_rd    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wait_last) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_wr    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request fields are captured only on acceptance so later input changes cannot disturb the store.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      ss_q     <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        addr_q <= addr;
        ss_q   <= ss_ctrl;
        data_q <= data_in;
      end
      if (state == S_READ) begin
        wait_cnt <= '0;
      end else if ((state == S_WAIT) && !wait_last) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
      if (wait_last) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Little-endian lane replacement into the word read back from memory.
  always_comb begin
    merged = rdata_q;
    if (ss_q == SS_FULL) begin
      merged = data_q;
    end else if (ss_q == SS_BYTE) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (addr_q[OFF_W-1:0] == OFF_W'(i)) begin
          merged[8*i +: 8] = data_q[7:0];
        end
      end
    end else if (ss_q == SS_HALF) begin
      for (int j = 0; j < NHALVES; j++) begin
        if (addr_q[OFF_W-1:1] == HOFF_W'(j)) begin
          merged[16*j +: 16] = data_q[15:0];
        end
      end
    end
  end

  assign mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata = (state == S_WRITE) ? merged : '0;

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// tb_store_unit: directed vectors against hand-computed bus activity for store_unit (DATA_W=32, MEM_LAT=1).
// Revision 1.0 -- initial release
module tb_store_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int MEM_LAT = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [1:0]        ss_ctrl;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  logic [31:0] mem [0:255];

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle activity after acceptance; bit c of each vector is cycle N+c.
  logic [7:0]  v_rd, v_wr, v_done, v_err, v_busy, v_wdz;
  logic [31:0] ad_at [0:7];
  logic [31:0] wd_at [0:7];
  logic [31:0] rd_addr, wr_addr, wr_data;

  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr[9:2]];
  end

  store_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .ss_ctrl  (ss_ctrl),
    .addr     (addr),
    .data_in  (data_in),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request before edge N, return at the negedge inside cycle N+1.
  task automatic issue(input logic [1:0] ss, input logic [31:0] a, input logic [31:0] d, input bit hold);
    @(negedge clk);
    start   = 1'b1;
    ss_ctrl = ss;
    addr    = a;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      start   = 1'b0;
      ss_ctrl = 2'b11;
      addr    = 32'hFFFF_FFFF;
      data_in = 32'h5555_AAAA;
    end
  endtask

  task automatic record(input int n);
    v_rd = '0; v_wr = '0; v_done = '0; v_err = '0; v_busy = '0; v_wdz = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    for (int k = 0; k < 8; k++) begin
      ad_at[k] = '0;
      wd_at[k] = '0;
    end
    for (int c = 1; c <= n; c++) begin
      v_rd[c]   = mem_rd;
      v_wr[c]   = mem_wr;
      v_done[c] = done;
      v_err[c]  = err;
      v_busy[c] = busy;
      ad_at[c]  = mem_addr;
      wd_at[c]  = mem_wdata;
      if (mem_rd) rd_addr = mem_addr;
      if (mem_wr) begin
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end else if (mem_wdata != '0) begin
        v_wdz[c] = 1'b1;
      end
      if (c < n) @(negedge clk);
    end
  endtask

  task automatic run(input string nm, input logic [1:0] ss, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] e_rd, input logic [7:0] e_wr, input logic [7:0] e_done,
                     input logic [7:0] e_err, input logic [31:0] e_addr, input logic [31:0] e_data);
    issue(ss, a, d, 1'b0);
    record(7);
    check({nm, "_rd"},    v_rd,    e_rd);
    check({nm, "_wr"},    v_wr,    e_wr);
    check({nm, "_done"},  v_done,  e_done);
    check({nm, "_err"},   v_err,   e_err);
    check({nm, "_busy"},  v_busy,  (e_done << 1) - 8'd2);
    check({nm, "_wdz"},   v_wdz,   8'h00);
    if (e_rd != 8'h00) check({nm, "_rdaddr"}, rd_addr, e_addr);
    if (e_wr != 8'h00) begin
      check({nm, "_wraddr"}, wr_addr, e_addr);
      check({nm, "_wdata"},  wr_data, e_data);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    ss_ctrl = 2'b00;
    addr    = '0;
    data_in = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hAABB_CCDD;
    mem[8'h41] = 32'h1122_3344;

    repeat (2) @(negedge clk);
    check("rst_ctrl", {busy, done, err, mem_rd, mem_wr}, 5'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    reset_n = 1'b1;

    //   name        ss     addr          data          rd     wr     done   err    addr          wdata
    run("byte102",  2'b10, 32'h0000_0102, 32'h0000_0011, 8'h02, 8'h08, 8'h10, 8'h00, 32'h0000_0100, 32'hAA11_CCDD);
    run("half102",  2'b01, 32'h0000_0102, 32'h0000_2233, 8'h02, 8'h08, 8'h10, 8'h00, 32'h0000_0100, 32'h2233_CCDD);
    run("full104",  2'b00, 32'h0000_0104, 32'hDEAD_BEEF, 8'h00, 8'h02, 8'h04, 8'h00, 32'h0000_0104, 32'hDEAD_BEEF);
    run("err_half", 2'b01, 32'h0000_0101, 32'h0000_1234, 8'h00, 8'h00, 8'h02, 8'h02, 32'h0,        32'h0);
    run("err_rsvd", 2'b11, 32'h0000_0100, 32'h0000_1234, 8'h00, 8'h00, 8'h02, 8'h02, 32'h0,        32'h0);
    run("err_full", 2'b00, 32'h0000_0102, 32'h0000_1234, 8'h00, 8'h00, 8'h02, 8'h02, 32'h0,        32'h0);
    run("byte103",  2'b10, 32'h0000_0103, 32'hFFFF_FF77, 8'h02, 8'h08, 8'h10, 8'h00, 32'h0000_0100, 32'h77BB_CCDD);
    run("byte100",  2'b10, 32'h0000_0100, 32'h0000_005A, 8'h02, 8'h08, 8'h10, 8'h00, 32'h0000_0100, 32'hAABB_CC5A);
    run("half100",  2'b01, 32'h0000_0100, 32'hFFFF_1234, 8'h02, 8'h08, 8'h10, 8'h00, 32'h0000_0100, 32'hAABB_1234);

    // Reset asserted during WAIT of a byte store.
    issue(2'b10, 32'h0000_0102, 32'h0000_0011, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {busy, done, err, mem_rd, mem_wr}, 5'b0);
    check("midrst_addr", mem_addr, 32'h0);
    check("midrst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    record(6);
    check("midrst_after_wr",   v_wr,   8'h00);
    check("midrst_after_done", v_done, 8'h00);
    check("midrst_after_busy", v_busy, 8'h00);
    run("post_rst", 2'b10, 32'h0000_0101, 32'h0000_00EE, 8'h02, 8'h08, 8'h10, 8'h00, 32'h0000_0100, 32'hAABB_EEDD);

    // Start held high: second full store accepted the cycle after done; inputs change mid-flight.
    issue(2'b00, 32'h0000_0108, 32'h0123_4567, 1'b1);
    addr    = 32'h0000_010C;
    data_in = 32'h89AB_CDEF;
    record(6);
    start = 1'b0;
    check("b2b_rd",    v_rd,     8'h00);
    check("b2b_wr",    v_wr,     8'h12);
    check("b2b_done",  v_done,   8'h24);
    check("b2b_addr1", ad_at[1], 32'h0000_0108);
    check("b2b_data1", wd_at[1], 32'h0123_4567);
    check("b2b_addr2", ad_at[4], 32'h0000_010C);
    check("b2b_data2", wd_at[4], 32'h89AB_CDEF);
    repeat (3) @(negedge clk);
    check("b2b_idle", {busy, mem_wr, done}, 3'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: memory word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 SHALL have parameter MEM_LAT, default 1: memory read latency in cycles, from the mem_rd cycle to mem_rdata valid; legal range 1..7.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: store request; sampled only in IDLE.
REQ-007 SHALL have port ss_ctrl, input, 2 bits: size select; 00 = full DATA_W, 01 = half (16), 10 = byte (8), 11 = reserved.
REQ-008 SHALL have port addr, input, ADDR_W bits: byte address of the store.
REQ-009 SHALL have port data_in, input, DATA_W bits: store data, right-justified for sub-word sizes.
REQ-010 SHALL have port mem_rdata, input, DATA_W bits: memory read data.
REQ-011 SHALL have port mem_addr, output, ADDR_W bits: word-aligned address (low log2(DATA_W/8) bits zero).
REQ-012 SHALL have port mem_rd, output, 1 bit: memory read strobe.
REQ-013 SHALL have port mem_wr, output, 1 bit: memory write strobe.
REQ-014 SHALL have port mem_wdata, output, DATA_W bits: merged write data.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have port err, output, 1 bit: one-cycle pulse, coincident with done, on a rejected request.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WAIT, WRITE, DONE, ERR.
REQ-019 SHALL, in IDLE with start=1, latch addr, ss_ctrl and data_in, then go to: ERR if ss_ctrl=11 or the address is misaligned; WRITE if ss_ctrl=00; otherwise READ.
REQ-020 SHALL treat the address as misaligned when ss_ctrl=01 with addr[0]=1, or ss_ctrl=00 with any of the low log2(DATA_W/8) bits nonzero; byte stores are never misaligned.
REQ-021 SHALL, in READ, assert mem_rd for exactly one cycle with the aligned mem_addr, then go to WAIT.
REQ-022 SHALL stay in WAIT for exactly MEM_LAT cycles, counted by an internal counter, and capture mem_rdata on the last WAIT cycle.
REQ-023 SHALL, in WRITE, assert mem_wr for exactly one cycle with mem_wdata as below, then go to DONE.
REQ-024 SHALL form mem_wdata for a full store as the latched data_in.
REQ-025 SHALL form mem_wdata for a sub-word store as the captured word with the addressed lane replaced, using little-endian lane selection.
REQ-026 SHALL place byte data at bits [8k+7:8k], where k = addr low bits.
REQ-027 SHALL place half data at bits [16j+15:16j], where j = addr[log2(DATA_W/8)-1:1].
REQ-028 SHALL pulse done for one cycle in DONE, then return to IDLE.
REQ-029 SHALL pulse done and err together for one cycle in ERR, then return to IDLE, with no mem_rd or mem_wr issued.
REQ-030 SHALL ignore start while busy=1; inputs changing mid-operation SHALL NOT affect the operation in flight.
REQ-031 SHALL accept start in the cycle after done (back-to-back stores).
REQ-032 SHALL meet these latencies, with start sampled at edge N: full store gives mem_wr in cycle N+1 and done in N+2; sub-word store gives mem_rd in N+1, mem_wr in N+2+MEM_LAT and done in N+3+MEM_LAT; error gives done/err in N+1.
REQ-033 SHALL hold mem_rd and mem_wr mutually exclusive; mem_addr stays constant from READ through WRITE.
REQ-034 SHALL drive mem_wdata to zero outside WRITE.

Reset
REQ-035 SHALL, on reset_n=0 at any time, immediately force the state to IDLE, the counter and latches to 0, and all outputs to 0.
REQ-036 SHALL, when reset occurs mid-operation, discard the operation: no mem_wr and no done afterwards.
REQ-037 SHALL leave the first start after reset_n deasserts to be sampled on the following rising edge.

Verification (DATA_W=32, MEM_LAT=1)
REQ-038 SHALL cover a byte store: memory 0x100 = 0xAABBCCDD, start with ss_ctrl=10, addr=0x102, data_in=0x00000011 -> mem_rd at N+1, mem_wr at N+3 with mem_addr=0x100 and mem_wdata=0xAA11CCDD, done at N+4.
REQ-039 SHALL cover a half store: same memory, ss_ctrl=01, addr=0x102, data_in=0x00002233 -> mem_wdata=0x2233CCDD.
REQ-040 SHALL cover a full store: ss_ctrl=00, addr=0x104, data_in=0xDEADBEEF -> no mem_rd, mem_wr at N+1 with 0xDEADBEEF to 0x104, done at N+2.
REQ-041 SHALL cover errors: ss_ctrl=01 with addr=0x101, and separately ss_ctrl=11 -> done=err=1 at N+1, mem_rd=mem_wr=0 throughout.
REQ-042 SHALL cover reset mid-operation: reset_n=0 during WAIT of a byte store -> all outputs 0 at once, no mem_wr or done; a subsequent store completes normally.
REQ-043 SHALL cover start held high continuously with back-to-back stores -> the second store is accepted the cycle after done; start pulses while busy are ignored.
